// File: rtl/rr_arb16_pkg.sv
// rtl/rr_arb16_pkg.sv - shared widths, state type and defaults for the rr_arb16 arbiter
package rr_arb16_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  // Default grant length limit, only meaningful when RR_ARB16_TIMEOUT_EN is defined
  localparam int HOLD_MAX_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sel_dec16.sv
// rtl/sel_dec16.sv - combinational 4-to-16 one-hot select decoder with active-high enable
module sel_dec16
  import rr_arb16_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] y
);

  // One line high for the selected index, all lines low when disabled
  always_comb begin
    y = '0;
    if (en) begin
      y[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arb16.sv
// rtl/rr_arb16.sv - 16-way round-robin arbiter with decoded one-hot grant; RR_ARB16_TIMEOUT_EN adds a hold limit
module rr_arb16
  import rr_arb16_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  arb_state_e       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic             revoke;

  // First set bit at or above p, wrapping 15->0. Scanning offsets downward lets the
  // smallest offset overwrite the result last, so it wins.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [IDX_W-1:0] p);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] j;
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = p + IDX_W'(i);
      if (r[j]) begin
        res = {1'b1, j};
      end
    end
    return res;
  endfunction

  // Candidate winner for the next arbitration, relative to the rotating pointer
  always_comb begin
    {win_found, win_idx} = rr_pick(req, ptr);
  end

  // Grant / hold / release sequencing; ptr moves past the winner so it ranks last next time
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      ptr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && win_found) begin
            gnt_idx   <= win_idx;
            gnt_valid <= 1'b1;
            ptr       <= win_idx + 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (!req[gnt_idx] || revoke) begin
            gnt_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RR_ARB16_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] hold_cnt;

  // A normal release on the limit cycle wins, so revoke requires the request still high
  assign revoke = (state == BUSY) && req[gnt_idx] && (hold_cnt == HOLD_LAST);

  // Counter sits at zero in IDLE so it starts from zero on entry to BUSY
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= revoke;
      if (state == IDLE) begin
        hold_cnt <= '0;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
`else
  assign revoke  = 1'b0;
  assign timeout = 1'b0;

  // Named marker block that only elaborates when HOLD_MAX is outside 1..255
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_out_of_range
  end
`endif

  sel_dec16 u_dec (
    .idx (gnt_idx),
    .en  (gnt_valid),
    .y   (gnt)
  );

endmodule

// File: tb/tb_rr_arb16.sv
// tb/tb_rr_arb16.sv - self-checking bench for rr_arb16 (directed plan plus randomized model comparison)
module tb_rr_arb16;

  localparam int HM = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] req;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        timeout;

  int checks   = 0;
  int failures = 0;

  // Reference state: whether a grant is live, who holds it, the rotation start and cycles held
  bit m_busy;
  int m_idx;
  int m_ptr;
  int m_hold;
  bit m_to;

  rr_arb16 #(.HOLD_MAX(HM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [15:0] r, input int p);
    for (int d = 0; d < 16; d++) begin
      if (r[(p + d) % 16]) return (p + d) % 16;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    if (!rst_n) begin
      m_busy = 0; m_idx = 0; m_ptr = 0; m_hold = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (!m_busy) begin
        w = pick(req, m_ptr);
        if (en && w >= 0) begin
          m_busy = 1; m_idx = w; m_ptr = (w + 1) % 16; m_hold = 0;
        end
      end else if (!req[m_idx]) begin
        m_busy = 0;
      end else begin
`ifdef RR_ARB16_TIMEOUT_EN
        if (m_hold == HM - 1) begin
          m_busy = 0; m_to = 1;
        end else begin
          m_hold++;
        end
`endif
      end
    end
  endtask

  task automatic step(input string tag);
    logic [15:0] exp_gnt;
    @(posedge clk);
    model_edge();
    #1;
    exp_gnt = m_busy ? (16'd1 << m_idx) : 16'd0;
    chk({tag, ".gnt"}, gnt, exp_gnt);
    chk({tag, ".gnt_idx"}, 16'(gnt_idx), 16'(m_idx));
    chk({tag, ".gnt_valid"}, 16'(gnt_valid), 16'(m_busy));
    chk({tag, ".timeout"}, 16'(timeout), 16'(m_to));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 16'hFFFF; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("reset");
      chk("reset.gnt_const", gnt, 16'h0000);
      chk("reset.idx_const", 16'(gnt_idx), 16'h0000);
      chk("reset.valid_const", 16'(gnt_valid), 16'h0000);
      chk("reset.timeout_const", 16'(timeout), 16'h0000);
    end
    rst_n = 1'b1; req = 16'h0000;
    step("post_reset");
  endtask

  initial begin
    int          order[4];
    int          n;
    int          c0;
    int          c15;
    bit          prev;
    logic [15:0] r;

    rst_n = 1'b0; en = 1'b0; req = 16'h0000;

    // Reset with every request asserted
    do_reset();

    // Single requester held three cycles
    req = 16'h0020;
    for (int i = 0; i < 3; i++) begin
      step("single");
      chk("single.gnt_const", gnt, 16'h0020);
      chk("single.idx_const", 16'(gnt_idx), 16'h0005);
    end
    req = 16'h0000;
    step("single_rel");
    chk("single_rel.gnt_const", gnt, 16'h0000);

    // Rotation between idx 0 and 15, each dropping for a cycle after two granted cycles
    do_reset();
    en = 1'b1; req = 16'h8001;
    n = 0; c0 = 0; c15 = 0; prev = 0;
    for (int i = 0; i < 4; i++) order[i] = 16'hFFFF;
    for (int cyc = 0; cyc < 30 && n < 4; cyc++) begin
      step("rot");
      if (gnt_valid && !prev) begin
        order[n] = int'(gnt_idx);
        n++;
      end
      prev = gnt_valid;
      req = 16'h8001;
      if (gnt_valid && gnt_idx == 4'd0) begin
        c0++;
        if (c0 == 2) begin req[0] = 1'b0; c0 = 0; end
      end
      if (gnt_valid && gnt_idx == 4'd15) begin
        c15++;
        if (c15 == 2) begin req[15] = 1'b0; c15 = 0; end
      end
    end
    chk("rot.order0", 16'(order[0]), 16'd0);
    chk("rot.order1", 16'(order[1]), 16'd15);
    chk("rot.order2", 16'(order[2]), 16'd0);
    chk("rot.order3", 16'(order[3]), 16'd15);

    // Wrap: grant 14, then 16'h4003 served as 0, 1, 14
    do_reset();
    req = 16'h4000;
    step("wrap_g14");
    chk("wrap_g14.idx_const", 16'(gnt_idx), 16'd14);
    req = 16'h0000;
    step("wrap_rel");
    req = 16'h4003;
    n = 0; prev = 0;
    for (int i = 0; i < 4; i++) order[i] = 16'hFFFF;
    for (int cyc = 0; cyc < 20 && n < 3; cyc++) begin
      step("wrap");
      if (gnt_valid && !prev) begin
        order[n] = int'(gnt_idx);
        n++;
      end
      prev = gnt_valid;
      if (gnt_valid) req[gnt_idx] = 1'b0;
    end
    chk("wrap.order0", 16'(order[0]), 16'd0);
    chk("wrap.order1", 16'(order[1]), 16'd1);
    chk("wrap.order2", 16'(order[2]), 16'd14);
    req = 16'h0000;
    step("wrap_idle");

    // Enable gating
    do_reset();
    en = 1'b0; req = 16'h0100;
    step("en_off"); chk("en_off.gnt_const", gnt, 16'h0000);
    step("en_off"); chk("en_off.gnt_const", gnt, 16'h0000);
    en = 1'b1;
    step("en_on"); chk("en_on.gnt_const", gnt, 16'h0100);
    en = 1'b0;
    step("en_drop"); chk("en_drop.gnt_const", gnt, 16'h0100);
    step("en_drop"); chk("en_drop.gnt_const", gnt, 16'h0100);
    req = 16'h0000;
    step("en_rel"); chk("en_rel.gnt_const", gnt, 16'h0000);

    // Hold limit behaviour with both requests held high
    do_reset();
    en = 1'b1; req = 16'h0009;
`ifdef RR_ARB16_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin step("to_a"); chk("to_a.gnt_const", gnt, 16'h0001); end
    step("to_rev0");
    chk("to_rev0.gnt_const", gnt, 16'h0000);
    chk("to_rev0.timeout_const", 16'(timeout), 16'h0001);
    for (int i = 0; i < 4; i++) begin step("to_b"); chk("to_b.gnt_const", gnt, 16'h0008); end
    step("to_rev3");
    chk("to_rev3.gnt_const", gnt, 16'h0000);
    chk("to_rev3.timeout_const", 16'(timeout), 16'h0001);
`else
    for (int i = 0; i < 12; i++) begin
      step("hold");
      chk("hold.gnt_const", gnt, 16'h0001);
      chk("hold.timeout_const", 16'(timeout), 16'h0000);
    end
`endif
    req = 16'h0000;
    step("hold_rel");

    // Randomized traffic: each request bit flips with probability 1/8 per cycle
    for (int i = 0; i < 800; i++) begin
      r = 16'($urandom & $urandom & $urandom);
      req = req ^ r;
      en = ($urandom_range(0, 7) != 0);
      rst_n = ($urandom_range(0, 99) != 0);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
